// File: rtl/sram_like_request_buffer_if.sv
// sram_like_request_buffer_if
//   Bundles the upstream request/response handshake and the SRAM-like bus
//   signals of one sram_like_request_buffer instance.
//   Signal groups:
//     req_*  : pipeline -> buffer request (valid/ready), write flag, strobe, address, data
//     resp_* : buffer -> pipeline response (valid/ready), write flag, read data
//     bus_*  : buffer <-> SRAM-like bus (req/addr_ok request phase, data_ok/rdata response phase)
//   Modports:
//     slave  : the buffer's view (serves the pipeline port, drives the bus)
//     master : the environment's view (pipeline plus memory system)
interface sram_like_request_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [STRB_WIDTH-1:0] req_strobe;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_write_data;

  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_write;
  logic [DATA_WIDTH-1:0] resp_data;

  logic                  bus_req;
  logic                  bus_wr;
  logic [STRB_WIDTH-1:0] bus_wstrb;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_addr_ok;
  logic                  bus_data_ok;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport slave (
    input  req_valid, req_write, req_strobe, req_address, req_write_data,
    output req_ready,
    output resp_valid, resp_write, resp_data,
    input  resp_ready,
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport master (
    output req_valid, req_write, req_strobe, req_address, req_write_data,
    input  req_ready,
    input  resp_valid, resp_write, resp_data,
    output resp_ready,
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/sram_like_request_buffer.sv
// sram_like_request_buffer
//   Bridges one valid/ready pipeline memory port onto an SRAM-like bus
//   (req/addr_ok/data_ok) with up to MAX_OUTSTANDING requests in flight.
//   A one-entry pending register holds the accepted request and drives the
//   bus directly; bus responses return in order into a RESP_DEPTH FIFO whose
//   head drives resp_*. A flush cancels every accepted, unreturned request;
//   the responses of cancelled requests are counted off and dropped.
//   Ports:
//     clock       : single clock, rising edge
//     reset_      : asynchronous reset, active low
//     flush       : cancel all accepted requests that have not yet returned
//     bus_if      : request, response and SRAM-like bus signals (slave view)
//     outstanding : live plus cancelled requests currently on the bus
module sram_like_request_buffer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RESP_DEPTH      = 2,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8,
  localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clock,
  input  logic                     reset_,
  input  logic                     flush,
  sram_like_request_buffer_if.slave bus_if,
  output logic [CNT_WIDTH-1:0]     outstanding
);
  localparam int PTR_WIDTH  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int FCNT_WIDTH = $clog2(RESP_DEPTH + 1);

  logic                  pending_valid_q, pending_valid_d;
  logic                  pending_cancel_q, pending_cancel_d;
  logic                  pending_write_q, pending_write_d;
  logic [STRB_WIDTH-1:0] pending_strobe_q, pending_strobe_d;
  logic [ADDR_WIDTH-1:0] pending_addr_q, pending_addr_d;
  logic [DATA_WIDTH-1:0] pending_wdata_q, pending_wdata_d;

  logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0]  cancel_count_q, cancel_count_d;
  logic [CNT_WIDTH-1:0]  live;
  logic [CNT_WIDTH-1:0]  slot;
  // Write flag of each request on the bus, oldest in bit 0.
  logic [MAX_OUTSTANDING-1:0] inflight_write_q, inflight_write_d;

  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FCNT_WIDTH-1:0] fifo_count_q, fifo_count_d;
  logic                  fifo_write_q [RESP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q  [RESP_DEPTH];

  logic                  accept, addr_hs, drop, push, pop, issue_ok;
  logic                  push_write;
  logic [DATA_WIDTH-1:0] push_data;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (32'(p) == 32'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Cancelled requests still occupy the bus, so the outstanding cap counts
  // them too; the FIFO reservation only needs the live ones, because
  // cancelled data never enters the FIFO. Neither term can grow while a
  // request waits in pending, so bus_req stays high until addr_ok.
  assign live     = outstanding_q - cancel_count_q;
  assign issue_ok = (32'(outstanding_q) < 32'(MAX_OUTSTANDING)) &&
                    ((32'(live) + 32'(fifo_count_q)) < 32'(RESP_DEPTH));

  assign bus_if.req_ready  = !pending_valid_q && !flush;
  assign bus_if.bus_req    = pending_valid_q && issue_ok;
  assign bus_if.bus_wr     = pending_write_q;
  assign bus_if.bus_wstrb  = pending_strobe_q;
  assign bus_if.bus_addr   = pending_addr_q;
  assign bus_if.bus_wdata  = pending_wdata_q;

  assign bus_if.resp_valid = (fifo_count_q != '0);
  assign bus_if.resp_write = bus_if.resp_valid && fifo_write_q[rd_ptr_q];
  assign bus_if.resp_data  = bus_if.resp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign outstanding       = outstanding_q;

  assign accept  = bus_if.req_valid && bus_if.req_ready;
  assign addr_hs = bus_if.bus_req && bus_if.bus_addr_ok;
  assign drop    = bus_if.bus_data_ok && (cancel_count_q != '0);
  // Data returning in the flush cycle belongs to a cancelled request.
  assign push    = bus_if.bus_data_ok && (cancel_count_q == '0) && !flush;
  assign pop     = bus_if.resp_valid && bus_if.resp_ready && !flush;

  assign push_write = inflight_write_q[0];
  assign push_data  = push_write ? '0 : bus_if.bus_rdata;
  assign slot       = outstanding_q - CNT_WIDTH'(bus_if.bus_data_ok);

  always_comb begin
    pending_valid_d  = pending_valid_q;
    pending_cancel_d = pending_cancel_q;
    pending_write_d  = pending_write_q;
    pending_strobe_d = pending_strobe_q;
    pending_addr_d   = pending_addr_q;
    pending_wdata_d  = pending_wdata_q;

    if (addr_hs) begin
      pending_valid_d  = 1'b0;
      pending_cancel_d = 1'b0;
    end else if (flush) begin
      // A request already shown on the bus must complete its address phase;
      // one not yet shown can simply vanish.
      if (bus_if.bus_req) begin
        pending_cancel_d = 1'b1;
      end else begin
        pending_valid_d  = 1'b0;
      end
    end

    if (accept) begin
      pending_valid_d  = 1'b1;
      pending_cancel_d = 1'b0;
      pending_write_d  = bus_if.req_write;
      pending_strobe_d = bus_if.req_strobe;
      pending_addr_d   = bus_if.req_address;
      pending_wdata_d  = bus_if.req_write_data;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q + CNT_WIDTH'(addr_hs) - CNT_WIDTH'(bus_if.bus_data_ok);

    // On flush everything still on the bus after this edge is cancelled,
    // which is exactly the next outstanding value.
    if (flush) begin
      cancel_count_d = outstanding_d;
    end else begin
      cancel_count_d = cancel_count_q + CNT_WIDTH'(addr_hs && pending_cancel_q)
                       - CNT_WIDTH'(drop);
    end

    inflight_write_d = bus_if.bus_data_ok ? (inflight_write_q >> 1) : inflight_write_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (addr_hs && (slot == CNT_WIDTH'(i))) begin
        inflight_write_d[i] = pending_write_q;
      end
    end
  end

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_count_d = fifo_count_q;
    if (flush) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      fifo_count_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      fifo_count_d = fifo_count_q + FCNT_WIDTH'(push) - FCNT_WIDTH'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      pending_valid_q  <= 1'b0;
      pending_cancel_q <= 1'b0;
      pending_write_q  <= 1'b0;
      pending_strobe_q <= '0;
      pending_addr_q   <= '0;
      pending_wdata_q  <= '0;
      outstanding_q    <= '0;
      cancel_count_q   <= '0;
      inflight_write_q <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      fifo_count_q     <= '0;
    end else begin
      pending_valid_q  <= pending_valid_d;
      pending_cancel_q <= pending_cancel_d;
      pending_write_q  <= pending_write_d;
      pending_strobe_q <= pending_strobe_d;
      pending_addr_q   <= pending_addr_d;
      pending_wdata_q  <= pending_wdata_d;
      outstanding_q    <= outstanding_d;
      cancel_count_q   <= cancel_count_d;
      inflight_write_q <= inflight_write_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      fifo_count_q     <= fifo_count_d;
    end
  end

  // Storage needs no reset: entries are only visible behind fifo_count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wr_ptr_q]  <= push_data;
      fifo_write_q[wr_ptr_q] <= push_write;
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clock) disable iff (!reset_)
    !(push && (32'(fifo_count_q) >= 32'(RESP_DEPTH))))
    else $fatal(1, "response FIFO overflow");

endmodule

// File: tb/tb_sram_like_request_buffer.sv
module tb_sram_like_request_buffer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int RD = 2;

  logic       clock = 1'b0;
  logic       reset_ = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] outstanding;

  sram_like_request_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  sram_like_request_buffer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .RESP_DEPTH(RD)
  ) dut (
    .clock(clock), .reset_(reset_), .flush(flush), .bus_if(bif), .outstanding(outstanding)
  );

  initial forever #5 clock = ~clock;

  typedef struct { logic wr; logic [3:0] strb; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { logic wr; logic [31:0] data; int due; } fly_t;
  typedef struct { logic wr; logic [31:0] data; } rsp_t;

  req_t        send_q[$];
  fly_t        fly_q[$];
  rsp_t        got_q[$];
  logic [31:0] ovr_q[$];

  int cyc, hs_count, dok_count, max_out, lat;
  bit addr_ok_en, data_ok_en;
  int total = 0;
  int bad = 0;

  // Memory image seen by the bus model: address XOR a fixed pattern.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic req_t rd_req(input logic [31:0] a);
    req_t r;
    r.wr = 1'b0; r.strb = 4'h0; r.addr = a; r.wdata = 32'h0;
    return r;
  endfunction

  // One clock cycle: drive request and bus inputs, sample handshakes just
  // before the rising edge, update the bus/reference model after it.
  task automatic tick();
    rsp_t r;
    fly_t f;
    logic s_hs, s_dok, s_acc, s_pop;
    if (send_q.size() > 0) begin
      bif.req_valid      = 1'b1;
      bif.req_write      = send_q[0].wr;
      bif.req_strobe     = send_q[0].strb;
      bif.req_address    = send_q[0].addr;
      bif.req_write_data = send_q[0].wdata;
    end else begin
      bif.req_valid = 1'b0;
    end
    bif.bus_addr_ok = addr_ok_en;
    if (data_ok_en && fly_q.size() > 0 && fly_q[0].due <= cyc + 1) begin
      bif.bus_data_ok = 1'b1;
      bif.bus_rdata   = fly_q[0].data;
    end else begin
      bif.bus_data_ok = 1'b0;
      bif.bus_rdata   = 32'hFFFF_FFFF;
    end
    #4;
    s_hs  = bif.bus_req && bif.bus_addr_ok;
    s_dok = bif.bus_data_ok;
    s_acc = bif.req_valid && bif.req_ready;
    s_pop = bif.resp_valid && bif.resp_ready && !flush;
    if (s_pop) begin
      r.wr = bif.resp_write;
      r.data = bif.resp_data;
      got_q.push_back(r);
      $display("resp  cyc=%0d write=%0d data=%08h", cyc, r.wr, r.data);
    end
    f.wr = 1'b0; f.data = 32'h0; f.due = 0;
    if (s_hs) begin
      f.wr = bif.bus_wr;
      if (ovr_q.size() > 0) f.data = ovr_q.pop_front();
      else f.data = memf(bif.bus_addr);
      f.due = cyc + 1 + lat;
      $display("issue cyc=%0d write=%0d addr=%08h", cyc, bif.bus_wr, bif.bus_addr);
    end
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
    @(posedge clock);
    cyc++;
    if (s_dok) begin
      void'(fly_q.pop_front());
      dok_count++;
    end
    if (s_hs) begin
      fly_q.push_back(f);
      hs_count++;
    end
    if (s_acc) void'(send_q.pop_front());
    @(negedge clock);
  endtask

  task automatic start_test(input int latency);
    got_q.delete();
    lat = latency; addr_ok_en = 1'b1; data_ok_en = 1'b1;
    hs_count = 0; dok_count = 0; max_out = 0;
    bif.resp_ready = 1'b1;
  endtask

  task automatic test_reset();
    bif.req_valid = 1'b0; bif.req_write = 1'b0; bif.req_strobe = '0;
    bif.req_address = '0; bif.req_write_data = '0; bif.resp_ready = 1'b1;
    bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b0; bif.bus_rdata = '0;
    cyc = 0;
    #2 reset_ = 1'b0;
    @(negedge clock);
    total++;
    if ({bif.req_ready, bif.resp_valid, bif.resp_write, bif.bus_req, bif.bus_wr} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags got=%b expected=%b",
        {bif.req_ready, bif.resp_valid, bif.resp_write, bif.bus_req, bif.bus_wr}, 5'b10000);
    end
    total++;
    if ({bif.bus_addr, bif.bus_wdata, bif.bus_wstrb} !== 68'h0) begin
      bad++; $display("FAIL reset_bus got=%h expected=0", {bif.bus_addr, bif.bus_wdata, bif.bus_wstrb});
    end
    total++;
    if (bif.resp_data !== 32'h0) begin
      bad++; $display("FAIL reset_resp_data got=%h expected=0", bif.resp_data);
    end
    total++;
    if (outstanding !== 2'd0) begin
      bad++; $display("FAIL reset_outstanding got=%0d expected=0", outstanding);
    end
    reset_ = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h5A5A_0100; exp_d[1] = 32'h5A5A_0104; exp_d[2] = 32'h5A5A_0108;
    start_test(3);
    send_q.push_back(rd_req(32'h100));
    send_q.push_back(rd_req(32'h104));
    send_q.push_back(rd_req(32'h108));
    for (int i = 0; i < 40 && got_q.size() < 3; i++) tick();
    repeat (2) tick();
    total++;
    if (got_q.size() != 3) begin
      bad++; $display("FAIL b2b_count got=%0d expected=3", got_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= got_q.size()) begin
        bad++; $display("FAIL b2b_data%0d got=missing expected=%h", i, exp_d[i]);
      end else if ({got_q[i].wr, got_q[i].data} !== {1'b0, exp_d[i]}) begin
        bad++; $display("FAIL b2b_data%0d got=%0d/%h expected=0/%h", i, got_q[i].wr, got_q[i].data, exp_d[i]);
      end
    end
    total++;
    if (max_out != 2) begin
      bad++; $display("FAIL b2b_peak_outstanding got=%0d expected=2", max_out);
    end
    total++;
    if (outstanding !== 2'd0) begin
      bad++; $display("FAIL b2b_outstanding_end got=%0d expected=0", outstanding);
    end
  endtask

  task automatic test_write();
    req_t w;
    start_test(1);
    w.wr = 1'b1; w.strb = 4'b0110; w.addr = 32'h500; w.wdata = 32'h1234_5678;
    send_q.push_back(w);
    for (int i = 0; i < 10 && !bif.bus_req; i++) tick();
    total++;
    if ({bif.bus_req, bif.bus_wr, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata} !==
        {1'b1, 1'b1, 4'b0110, 32'h500, 32'h1234_5678}) begin
      bad++; $display("FAIL write_bus got=%b/%b/%b/%h/%h expected=1/1/0110/00000500/12345678",
        bif.bus_req, bif.bus_wr, bif.bus_wstrb, bif.bus_addr, bif.bus_wdata);
    end
    for (int i = 0; i < 20 && got_q.size() < 1; i++) tick();
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL write_resp_count got=%0d expected=1", got_q.size());
    end else if ({got_q[0].wr, got_q[0].data} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL write_resp got=%0d/%h expected=1/00000000", got_q[0].wr, got_q[0].data);
    end
  endtask

  task automatic test_cap();
    int dok_before;
    int prev;
    start_test(1);
    data_ok_en = 1'b0;
    send_q.push_back(rd_req(32'h110));
    send_q.push_back(rd_req(32'h114));
    send_q.push_back(rd_req(32'h118));
    repeat (10) tick();
    total++;
    if ({hs_count, int'(outstanding)} != {32'd2, 32'd2}) begin
      bad++; $display("FAIL cap_issued got hs=%0d out=%0d expected hs=2 out=2", hs_count, outstanding);
    end
    total++;
    if ({bif.bus_req, bif.req_ready} !== 2'b00) begin
      bad++; $display("FAIL cap_bus_req_low got req=%b ready=%b expected 0/0", bif.bus_req, bif.req_ready);
    end
    data_ok_en = 1'b1;
    dok_before = -1;
    for (int i = 0; i < 20 && hs_count < 3; i++) begin
      prev = dok_count;
      tick();
      if (hs_count == 3) dok_before = prev;
    end
    total++;
    if (dok_before < 1) begin
      bad++; $display("FAIL cap_third_issue data_ok_before=%0d expected>=1", dok_before);
    end
    for (int i = 0; i < 20 && got_q.size() < 3; i++) tick();
    total++;
    if (got_q.size() != 3) begin
      bad++; $display("FAIL cap_resp_count got=%0d expected=3", got_q.size());
    end else if (got_q[2].data !== 32'h5A5A_0118) begin
      bad++; $display("FAIL cap_third_data got=%h expected=5a5a0118", got_q[2].data);
    end
  endtask

  task automatic test_flush_mid_flight();
    start_test(1);
    data_ok_en = 1'b0;
    ovr_q.push_back(32'h0000_DEAD);
    ovr_q.push_back(32'h0000_BEEF);
    send_q.push_back(rd_req(32'h180));
    send_q.push_back(rd_req(32'h184));
    for (int i = 0; i < 20 && outstanding != 2'd2; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (dut.cancel_count_q !== 2'd2) begin
      bad++; $display("FAIL flush_cancel_count got=%0d expected=2", dut.cancel_count_q);
    end
    data_ok_en = 1'b1;
    send_q.push_back(rd_req(32'h200));
    for (int i = 0; i < 30 && got_q.size() < 1; i++) tick();
    repeat (3) tick();
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL flush_resp_count got=%0d expected=1", got_q.size());
    end else if (got_q[0].data !== 32'h5A5A_0200) begin
      bad++; $display("FAIL flush_post_data got=%h expected=5a5a0200", got_q[0].data);
    end
    total++;
    if ({outstanding, dut.cancel_count_q} !== 4'b0000) begin
      bad++; $display("FAIL flush_counters got out=%0d cancel=%0d expected 0/0", outstanding, dut.cancel_count_q);
    end
  endtask

  task automatic test_flush_pending();
    start_test(1);
    addr_ok_en = 1'b0;
    send_q.push_back(rd_req(32'h300));
    for (int i = 0; i < 10 && !bif.bus_req; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (2) tick();
    total++;
    if ({bif.bus_req, bif.bus_addr} !== {1'b1, 32'h300}) begin
      bad++; $display("FAIL flushpend_hold got req=%b addr=%h expected 1/00000300", bif.bus_req, bif.bus_addr);
    end
    total++;
    if (dut.pending_cancel_q !== 1'b1) begin
      bad++; $display("FAIL flushpend_cancel_flag got=%b expected=1", dut.pending_cancel_q);
    end
    addr_ok_en = 1'b1;
    repeat (10) tick();
    total++;
    if ({got_q.size(), hs_count} != {32'd0, 32'd1}) begin
      bad++; $display("FAIL flushpend_dropped got resp=%0d issued=%0d expected 0/1", got_q.size(), hs_count);
    end
    total++;
    if ({outstanding, dut.cancel_count_q} !== 4'b0000) begin
      bad++; $display("FAIL flushpend_counters got out=%0d cancel=%0d expected 0/0", outstanding, dut.cancel_count_q);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h5A5A_0400; exp_d[1] = 32'h5A5A_0404;
    exp_d[2] = 32'h5A5A_0408; exp_d[3] = 32'h5A5A_040C;
    start_test(1);
    bif.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_q.push_back(rd_req(32'h400 + 32'(4 * i)));
    repeat (20) tick();
    total++;
    if ({bif.resp_valid, bif.resp_data} !== {1'b1, 32'h5A5A_0400}) begin
      bad++; $display("FAIL bp_head got valid=%b data=%h expected 1/5a5a0400", bif.resp_valid, bif.resp_data);
    end
    total++;
    if (dut.fifo_count_q !== 2'd2) begin
      bad++; $display("FAIL bp_buffered got=%0d expected=2", dut.fifo_count_q);
    end
    total++;
    if ({bif.bus_req, outstanding} !== 3'b000) begin
      bad++; $display("FAIL bp_bus_held got req=%b out=%0d expected 0/0", bif.bus_req, outstanding);
    end
    bif.resp_ready = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < 4; i++) tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got_q.size()) begin
        bad++; $display("FAIL bp_data%0d got=missing expected=%h", i, exp_d[i]);
      end else if (got_q[i].data !== exp_d[i]) begin
        bad++; $display("FAIL bp_data%0d got=%h expected=%h", i, got_q[i].data, exp_d[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    start_test(1);
    data_ok_en = 1'b0;
    send_q.push_back(rd_req(32'h600));
    send_q.push_back(rd_req(32'h604));
    send_q.push_back(rd_req(32'h608));
    repeat (8) tick();
    total++;
    if ({outstanding, bif.req_ready} !== 3'b100) begin
      bad++; $display("FAIL areset_pre got out=%0d ready=%b expected 2/0", outstanding, bif.req_ready);
    end
    #2 reset_ = 1'b0;
    #1;
    total++;
    if ({bif.req_ready, bif.resp_valid, bif.resp_write, bif.bus_req, bif.bus_wr} !== 5'b10000) begin
      bad++; $display("FAIL areset_flags got=%b expected=10000",
        {bif.req_ready, bif.resp_valid, bif.resp_write, bif.bus_req, bif.bus_wr});
    end
    total++;
    if ({outstanding, bif.bus_addr, bif.resp_data} !== 66'h0) begin
      bad++; $display("FAIL areset_values got out=%0d addr=%h data=%h expected 0", outstanding, bif.bus_addr, bif.resp_data);
    end
    @(negedge clock);
    send_q.delete(); fly_q.delete(); got_q.delete(); ovr_q.delete();
    reset_ = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_write();
    test_cap();
    test_flush_mid_flight();
    test_flush_pending();
    test_backpressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
